// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: accumulator-based command sequencer driving a combinational ALU.
// Optional feature macro ALU_ISSUE_CTRL_PIPE_EN lets a response handshake and the next command accept share a cycle.
module alu_issue_ctrl #(
  parameter int unsigned W       = 16,
  parameter int unsigned ALU_LAT = 1,
  parameter logic [4:0]  OP_TST  = 5'b01111,
  parameter logic [4:0]  OP_LDA  = 5'b11111
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [4:0]   cmd_op,
  input  logic [W-1:0] cmd_operand,
  output logic [4:0]   alu_op,
  output logic [W-1:0] alu_operandA,
  output logic [W-1:0] alu_operandB,
  input  logic [W-1:0] alu_result,
  input  logic [3:0]   alu_flags,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_result,
  output logic [3:0]   rsp_flags
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(ALU_LAT - 1);

  state_t       state;
  logic [W-1:0] acc;
  logic [3:0]   flags_reg;
  logic [3:0]   cnt;
  logic         accept;

`ifdef ALU_ISSUE_CTRL_PIPE_EN
  assign cmd_ready = !rst && ((state == IDLE) || ((state == RESP) && rsp_ready));
`else
  assign cmd_ready = !rst && (state == IDLE);
`endif

  assign accept     = cmd_valid && cmd_ready;
  assign rsp_result = acc;
  assign rsp_flags  = flags_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      acc          <= '0;
      flags_reg    <= '0;
      cnt          <= '0;
      alu_op       <= '0;
      alu_operandA <= '0;
      alu_operandB <= '0;
      rsp_valid    <= 1'b0;
    end else if (accept) begin
      // accept is only possible in IDLE or in RESP while the response is being taken
      if (cmd_op == OP_LDA) begin
        acc       <= cmd_operand;
        rsp_valid <= 1'b1;
        state     <= RESP;
      end else begin
        alu_op       <= cmd_op;
        alu_operandA <= acc;
        alu_operandB <= cmd_operand;
        cnt          <= CNT_INIT;
        rsp_valid    <= 1'b0;
        state        <= EXEC;
      end
    end else begin
      case (state)
        EXEC: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            flags_reg <= alu_flags;
            if (alu_op != OP_TST) begin
              acc <= alu_result;
            end
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
